// File: rtl/div_pkg.sv
// Shared types for the iterative divider: RV32M opcode encoding and FSM states.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on a WIDTH+1 bit partial remainder.
// Zero latency; no handshake, chained BITS_PER_CYCLE times by the divider.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // The top bit of diff is a clean borrow because the incoming remainder is below the divisor.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {2'b00, divisor};
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU; WIDTH/BITS_PER_CYCLE+2 cycles, special cases 1.
// Takes a request only when idle; the response is held until resp_ready.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  div_op_t          op,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] y,
    output logic             dz,
    output logic             ovf
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state, state_nxt;
    div_op_t          op_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             q_neg, r_neg;
    logic [CW-1:0]    cnt;

    logic             is_signed, is_rem, s1, s2, zero_div, ovf_case, special;
    logic [WIDTH-1:0] abs1, abs2;

    always_comb begin
        is_signed = (op == DIV) || (op == REM);
        is_rem    = (op == REM) || (op == REMU);
        s1        = is_signed & x1[WIDTH-1];
        s2        = is_signed & x2[WIDTH-1];
        abs1      = s1 ? -x1 : x1;
        abs2      = s2 ? -x2 : x2;
        zero_div  = (x2 == '0);
        ovf_case  = is_signed && (x1 == MIN_VAL) && (x2 == '1);
        special   = zero_div | ovf_case;
    end

    logic [WIDTH:0]          rem_chain [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] q_bits;

    assign rem_chain[0] = rem_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_in  (rem_chain[i]),
            .bit_in  (quo_q[WIDTH-1-i]),
            .divisor (dvs_q),
            .rem_out (rem_chain[i+1]),
            .q_bit   (q_bits[BITS_PER_CYCLE-1-i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (req_valid) state_nxt = special ? DONE : CALC;
            CALC: if (cnt == CW'(STEPS - 1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (resp_ready) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == DONE);
    end

    // Dividend bits shift out of quo_q's top as quotient bits shift into its bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= DIVU;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            cnt   <= '0;
            y     <= '0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (req_valid) begin
                    op_q  <= op;
                    rem_q <= '0;
                    quo_q <= abs1;
                    dvs_q <= abs2;
                    q_neg <= s1 ^ s2;
                    r_neg <= s1;
                    cnt   <= '0;
                    dz    <= zero_div;
                    ovf   <= ovf_case;
                    if (zero_div)      y <= is_rem ? x1 : '1;
                    else if (ovf_case) y <= is_rem ? '0 : x1;
                end
                CALC: begin
                    rem_q <= rem_chain[BITS_PER_CYCLE];
                    quo_q <= {quo_q[WIDTH-1-BITS_PER_CYCLE:0], q_bits};
                    cnt   <= cnt + CW'(1);
                end
                FIX: begin
                    if ((op_q == REM) || (op_q == REMU))
                        y <= r_neg ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    else
                        y <= q_neg ? -quo_q : quo_q;
                end
                DONE: ;
            endcase
        end
    end

endmodule
